pid_ctrl_pipe: RTL and testbench

PID_CTRL_PIPE -- requirements
Module: pid_ctrl_pipe

---
 rtl/pid_ctrl_pipe.sv | 188 ++++++++++++++++++
 tb/tb_pid_ctrl_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl_pipe.sv
// Two-stage pipelined PID steering controller: error -> saturated P/I/D terms -> clamped wheel speeds.
// Define PID_I_TERM_EN to build the integrator, its I term and the i_frz overflow flag.
module pid_ctrl_pipe #(
    parameter int ERR_W   = 12,
    parameter int SAT_W   = 10,
    parameter int FRWRD_W = 10,
    parameter int D_DEPTH = 3,
    parameter int P_COEFF = 16,
    parameter int D_COEFF = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [FRWRD_W-1:0]      frwrd,
    output logic [FRWRD_W:0]        lft_spd,
    output logic [FRWRD_W:0]        rght_spd,
    output logic                    spd_vld,
    output logic                    i_frz
);

    localparam int PID_W = SAT_W + 4;
    localparam int IW    = SAT_W + 5;
    localparam int PW    = SAT_W + 7;
    localparam int SW    = FRWRD_W + 2;
    localparam logic [5:0] P_K = P_COEFF[5:0];
    localparam logic [4:0] D_K = D_COEFF[4:0];
    localparam logic signed [SAT_W:0] DIFF_MAX = (SAT_W+1)'(127);
    localparam logic signed [SAT_W:0] DIFF_MIN = (SAT_W+1)'(-128);

    logic signed [SAT_W-1:0] w_err_sat;
    logic signed [SAT_W-1:0] r_hist [D_DEPTH];
    logic signed [SAT_W-1:0] w_prev;
    logic signed [SAT_W:0]   w_diff;
    logic signed [7:0]       w_d_diff;
    logic signed [PW-1:0]    w_p_full;
    logic signed [PID_W-1:0] w_p_term;
    logic signed [PID_W-1:0] w_d_term;
    logic signed [PID_W-1:0] w_i_term;

    logic                    r_s1_vld;
    logic signed [PID_W-1:0] r_s1_p;
    logic signed [PID_W-1:0] r_s1_i;
    logic signed [PID_W-1:0] r_s1_d;
    logic [FRWRD_W-1:0]      r_s1_frwrd;

    logic signed [PID_W-1:0] w_pid;
    logic signed [PID_W-1:0] w_steer;
    logic signed [SW-1:0]    w_lft;
    logic signed [SW-1:0]    w_rght;
    logic [FRWRD_W:0]        r_lft_spd;
    logic [FRWRD_W:0]        r_rght_spd;
    logic                    r_spd_vld;

    generate
        if (ERR_W > SAT_W) begin : g_sat
            localparam logic signed [ERR_W-1:0] SAT_MAX = ERR_W'((2 ** (SAT_W - 1)) - 1);
            localparam logic signed [ERR_W-1:0] SAT_MIN = ~SAT_MAX;
            always_comb begin
                if (error > SAT_MAX)
                    w_err_sat = SAT_W'(SAT_MAX);
                else if (error < SAT_MIN)
                    w_err_sat = SAT_W'(SAT_MIN);
                else
                    w_err_sat = error[SAT_W-1:0];
            end
        end else begin : g_nosat
            assign w_err_sat = error;
        end
    endgenerate

    // History shifts on every strobe, even while stopped, so D stays meaningful on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
        end else if (err_vld) begin
            for (int k = D_DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
            r_hist[0] <= w_err_sat;
        end
    end

    assign w_prev = r_hist[D_DEPTH-1];
    assign w_diff = (SAT_W+1)'(w_err_sat) - (SAT_W+1)'(w_prev);

    always_comb begin
        if (w_diff > DIFF_MAX)
            w_d_diff = 8'sd127;
        else if (w_diff < DIFF_MIN)
            w_d_diff = -8'sd128;
        else
            w_d_diff = w_diff[7:0];
    end

    assign w_p_full = PW'(w_err_sat) * $signed(PW'(P_K));
    assign w_p_term = PID_W'(w_p_full >>> 1);
    assign w_d_term = PID_W'(w_d_diff) * $signed(PID_W'(D_K));

`ifdef PID_I_TERM_EN
    logic signed [IW-1:0] r_integ;
    logic signed [IW-1:0] w_sum;
    logic                 w_ovf;
    logic                 r_i_frz;

    assign w_sum = r_integ + IW'(w_err_sat);
    // Same-sign operands producing an opposite-sign sum means the add wrapped.
    assign w_ovf = (r_integ[IW-1] == w_err_sat[SAT_W-1]) && (w_sum[IW-1] != r_integ[IW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ <= '0;
            r_i_frz <= 1'b0;
        end else if (!moving) begin
            r_integ <= '0;
            r_i_frz <= 1'b0;
        end else if (err_vld) begin
            if (w_ovf) begin
                r_i_frz <= 1'b1;
            end else begin
                r_integ <= w_sum;
                r_i_frz <= 1'b0;
            end
        end
    end

    assign w_i_term = PID_W'($signed(r_integ[IW-1:6]));
    assign i_frz    = r_i_frz;
`else
    assign w_i_term = '0;
    assign i_frz    = 1'b0;
`endif

    // Stage 1 sees the integrator before this sample's update lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_p     <= '0;
            r_s1_i     <= '0;
            r_s1_d     <= '0;
            r_s1_frwrd <= '0;
        end else begin
            r_s1_vld <= err_vld & moving;
            if (err_vld) begin
                r_s1_p     <= w_p_term;
                r_s1_i     <= w_i_term;
                r_s1_d     <= w_d_term;
                r_s1_frwrd <= frwrd;
            end
        end
    end

    assign w_pid   = r_s1_p + r_s1_i + r_s1_d;
    assign w_steer = w_pid >>> 3;
    assign w_lft   = $signed({2'b00, r_s1_frwrd}) + SW'(w_steer);
    assign w_rght  = $signed({2'b00, r_s1_frwrd}) - SW'(w_steer);

    function automatic logic [FRWRD_W:0] clamp_spd(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v[FRWRD_W])
            return {1'b0, {FRWRD_W{1'b1}}};
        else
            return {1'b0, v[FRWRD_W-1:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_spd  <= '0;
            r_rght_spd <= '0;
            r_spd_vld  <= 1'b0;
        end else if (!moving) begin
            r_lft_spd  <= '0;
            r_rght_spd <= '0;
            r_spd_vld  <= 1'b0;
        end else if (r_s1_vld) begin
            r_lft_spd  <= clamp_spd(w_lft);
            r_rght_spd <= clamp_spd(w_rght);
            r_spd_vld  <= 1'b1;
        end else begin
            r_spd_vld  <= 1'b0;
        end
    end

    assign lft_spd  = r_lft_spd;
    assign rght_spd = r_rght_spd;
    assign spd_vld  = r_spd_vld;

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Self-checking bench for pid_ctrl_pipe: hand vectors, corner sequences, and random traffic vs. an arithmetic model.
// Honours PID_I_TERM_EN the same way the design does.
module tb_pid_ctrl_pipe;

    localparam int ERR_W   = 12;
    localparam int SAT_W   = 10;
    localparam int FRWRD_W = 10;
    localparam int D_DEPTH = 3;
    localparam int P_COEFF = 16;
    localparam int D_COEFF = 7;
    localparam int IMAX    = (2 ** (SAT_W + 4)) - 1;
    localparam int IMIN    = -(2 ** (SAT_W + 4));
`ifdef PID_I_TERM_EN
    localparam bit I_EN = 1'b1;
`else
    localparam bit I_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    moving = 1'b0;
    logic                    err_vld = 1'b0;
    logic signed [ERR_W-1:0] error = '0;
    logic [FRWRD_W-1:0]      frwrd = '0;
    logic [FRWRD_W:0]        lft_spd;
    logic [FRWRD_W:0]        rght_spd;
    logic                    spd_vld;
    logic                    i_frz;

    pid_ctrl_pipe #(
        .ERR_W(ERR_W), .SAT_W(SAT_W), .FRWRD_W(FRWRD_W),
        .D_DEPTH(D_DEPTH), .P_COEFF(P_COEFF), .D_COEFF(D_COEFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld),
        .error(error), .frwrd(frwrd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .spd_vld(spd_vld), .i_frz(i_frz)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_hist [D_DEPTH];
    int m_integ, m_s1_l, m_s1_r, m_l, m_r;
    bit m_frz, m_s1_vld, m_vld;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic calc(input int es, input int prev, input int integ, input int fr,
                        output int l, output int r);
        int p2, d, i, pid, st;
        p2  = (es * P_COEFF) >>> 1;
        d   = clampi(es - prev, -128, 127) * D_COEFF;
        i   = I_EN ? (integ >>> 6) : 0;
        pid = ((p2 + i + d) <<< (32 - (SAT_W + 4))) >>> (32 - (SAT_W + 4));
        st  = pid >>> 3;
        l   = clampi(fr + st, 0, 2 ** FRWRD_W - 1);
        r   = clampi(fr - st, 0, 2 ** FRWRD_W - 1);
    endtask

    task automatic model_reset();
        for (int k = 0; k < D_DEPTH; k++) m_hist[k] = 0;
        m_integ = 0; m_frz = 0; m_s1_vld = 0; m_s1_l = 0; m_s1_r = 0;
        m_l = 0; m_r = 0; m_vld = 0;
    endtask

    task automatic model_edge(input bit mv, input bit ev, input int err, input int fr);
        int es, l, r, s;
        es = clampi(err, -(2 ** (SAT_W - 1)), 2 ** (SAT_W - 1) - 1);
        if (!mv) begin
            m_l = 0; m_r = 0; m_vld = 0;
        end else if (m_s1_vld) begin
            m_l = m_s1_l; m_r = m_s1_r; m_vld = 1;
        end else begin
            m_vld = 0;
        end
        if (ev) begin
            calc(es, m_hist[D_DEPTH-1], m_integ, fr, l, r);
            m_s1_l = l; m_s1_r = r;
        end
        m_s1_vld = ev && mv;
        if (!mv) begin
            m_integ = 0; m_frz = 0;
        end else if (ev) begin
            s = m_integ + es;
            if (s > IMAX || s < IMIN) m_frz = 1;
            else begin m_integ = s; m_frz = 0; end
        end
        if (ev) begin
            for (int k = D_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = es;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge(moving, err_vld, int'(error), int'(frwrd));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; err_vld = 1'b0;
        model_reset();
        #2;
        check("rst_lft", lft_spd, 0);
        check("rst_rght", rght_spd, 0);
        check("rst_vld", spd_vld, 0);
        check("rst_frz", i_frz, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sample(input int e);
        error = ERR_W'(e); err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        int err;
        int fr;
        int exp_l;
        int exp_r;
    } vec_t;

    vec_t vecs [7];
    int   seq_l [4];
    int   seq_r [4];
    int   t, mode;

    initial begin
        vecs[0] = '{2047, 512, 1023, 0};
        vecs[1] = '{0, 300, 300, 300};
        vecs[2] = '{-2048, 512, 0, 1023};
        vecs[3] = '{10, 400, 418, 382};
        vecs[4] = '{-10, 400, 381, 419};
        vecs[5] = '{100, 0, 187, 0};
        vecs[6] = '{5, 1023, 1023, 1014};

        // Single isolated samples from a clean reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            moving = 1'b1; frwrd = FRWRD_W'(vecs[v].fr);
            error = ERR_W'(vecs[v].err); err_vld = 1'b1;
            tick();
            err_vld = 1'b0;
            check("vec_vld_early", spd_vld, 0);
            tick();
            check("vec_lft", lft_spd, vecs[v].exp_l);
            check("vec_rght", rght_spd, vecs[v].exp_r);
            check("vec_vld", spd_vld, 1);
            frwrd = '0;
            tick();
            check("vec_vld_pulse", spd_vld, 0);
            check("vec_hold", lft_spd, vecs[v].exp_l);
            $display("vector %0d: err=%0d frwrd=%0d -> lft=%0d rght=%0d", v, vecs[v].err, vecs[v].fr, lft_spd, rght_spd);
        end

        // Step 0 -> 100 held, back-to-back strobes: derivative visible for exactly D_DEPTH samples
        seq_l = '{699, 699, 699, 612};
        seq_r = '{325, 325, 325, 412};
        do_reset();
        moving = 1'b1; frwrd = 10'd512; error = 12'sd100; err_vld = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) err_vld = 1'b0;
            tick();
            check("step_lft", lft_spd, seq_l[k]);
            check("step_rght", rght_spd, seq_r[k]);
            check("step_vld", spd_vld, 1);
            $display("step sample %0d: lft=%0d rght=%0d vld=%0d", k, lft_spd, rght_spd, spd_vld);
        end

        // Integrator saturation, freeze flag, then stop clears everything
        do_reset();
        moving = 1'b1; frwrd = 10'd512;
        for (int k = 1; k <= 32; k++) sample(511);
        check("frz_after32", i_frz, 0);
        sample(511);
        check("frz_after33", i_frz, I_EN ? 1 : 0);
        sample(0);
        check("iterm_lft", lft_spd, I_EN ? 431 : 400);
        check("iterm_rght", rght_spd, I_EN ? 593 : 624);
        check("frz_cleared", i_frz, 0);
        sample(511);
        check("frz_again", i_frz, I_EN ? 1 : 0);
        moving = 1'b0;
        tick();
        check("stop_lft", lft_spd, 0);
        check("stop_rght", rght_spd, 0);
        check("stop_frz", i_frz, 0);
        moving = 1'b1;
        sample(0);
        check("restart_lft", lft_spd, 400);
        check("restart_rght", rght_spd, 624);
        $display("integrator sequence done: lft=%0d rght=%0d frz=%0d", lft_spd, rght_spd, i_frz);

        // Reset one cycle after a strobe discards the in-flight sample
        do_reset();
        moving = 1'b1; frwrd = 10'd400;
        sample(10);
        check("pre_rst_lft", lft_spd, 418);
        error = 12'sd5; frwrd = 10'd1023; err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_lft", lft_spd, 0);
        check("async_rght", rght_spd, 0);
        check("async_vld", spd_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_vld", spd_vld, 0);
            check("post_rst_lft", lft_spd, 0);
        end
        $display("reset-in-flight sequence done");

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            moving  = ($urandom_range(0, 24) != 0);
            err_vld = ($urandom_range(0, 9) < 6);
            frwrd   = FRWRD_W'($urandom_range(0, 1023));
            mode    = int'($urandom_range(0, 3));
            if (mode == 0)
                error = ERR_W'($urandom);
            else if (mode == 1)
                error = ($urandom_range(0, 1) != 0) ? 12'sd2047 : -12'sd2048;
            else begin
                t = int'($urandom_range(0, 300)) - 150;
                error = ERR_W'(t);
            end
            tick();
            check("rnd_lft", lft_spd, m_l);
            check("rnd_rght", rght_spd, m_r);
            check("rnd_vld", spd_vld, int'(m_vld));
            check("rnd_frz", i_frz, I_EN ? int'(m_frz) : 0);
            if (spd_vld)
                $display("rnd cycle %0d: lft=%0d rght=%0d exp %0d/%0d", c, lft_spd, rght_spd, m_l, m_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
